// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port ram between the instruction-fetch (IF)
// and load/store (D) ports, with a single transaction in flight. Byte-masked
// stores are performed as read-modify-write because the ram only writes whole words.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN (round-robin arbitration on
// contention); when it is undefined, D has fixed priority over IF.
module ram_arbiter #(
    parameter int unsigned WORDSIZE = 4,
    parameter int unsigned MEMSIZE  = 32 * 1024,
    localparam int unsigned DW      = WORDSIZE * 8,
    localparam int unsigned AW      = $clog2(MEMSIZE)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [AW-1:0]       if_addr,
    output logic                if_rsp_valid,
    output logic [DW-1:0]       if_rsp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_we,
    input  logic [WORDSIZE-1:0] d_req_be,
    input  logic [AW-1:0]       d_addr,
    input  logic [DW-1:0]       d_wdata,
    output logic                d_rsp_valid,
    output logic [DW-1:0]       d_rsp_data,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic [AW-1:0]       mem_address,
    output logic [DW-1:0]       mem_data_i,
    input  logic [DW-1:0]       mem_data_o
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RMW, ACK} state_t;
    typedef enum logic {OWN_D, OWN_IF} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_grant_q, last_grant_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [WORDSIZE-1:0] be_q, be_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic                if_rsp_valid_q, if_rsp_valid_d;
    logic [DW-1:0]       if_rsp_data_q, if_rsp_data_d;
    logic                d_rsp_valid_q, d_rsp_valid_d;
    logic [DW-1:0]       d_rsp_data_q, d_rsp_data_d;

    logic                grant_d, grant_if;
    logic [DW-1:0]       merged;

    // Arbitration between the two requesters; only meaningful in IDLE.
    always_comb begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        grant_d = d_req_valid && (!if_req_valid || (last_grant_q == OWN_IF));
`else
        grant_d = d_req_valid;
`endif
        grant_if = if_req_valid && !grant_d;
    end

    // Byte merge of latched store data over the word read back from ram.
    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < WORDSIZE; i++) begin
            merged[i*8 +: 8] = be_q[i] ? wdata_q[i*8 +: 8] : mem_data_o[i*8 +: 8];
        end
    end

    // Next-state, handshake and ram control decode.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        if_rsp_valid_d = 1'b0;
        if_rsp_data_d  = if_rsp_data_q;
        d_rsp_valid_d  = 1'b0;
        d_rsp_data_d   = d_rsp_data_q;
        if_req_ready   = 1'b0;
        d_req_ready    = 1'b0;
        mem_read_en    = 1'b0;
        mem_write_en   = 1'b0;
        mem_address    = '0;
        mem_data_i     = '0;

        case (state_q)
            IDLE: begin
                if (reset_n && grant_d) begin
                    d_req_ready  = 1'b1;
                    owner_d      = OWN_D;
                    last_grant_d = OWN_D;
                    addr_d       = d_addr;
                    be_d         = d_req_be;
                    wdata_d      = d_wdata;
                    mem_address  = d_addr;
                    if (!d_req_we) begin
                        mem_read_en = 1'b1;
                        state_d     = RD_WAIT;
                    end else if (&d_req_be) begin
                        mem_write_en  = 1'b1;
                        mem_data_i    = d_wdata;
                        state_d       = ACK;
                        d_rsp_valid_d = 1'b1;
                        d_rsp_data_d  = '0;
                    end else if (|d_req_be) begin
                        mem_read_en = 1'b1;
                        state_d     = RMW;
                    end else begin
                        mem_address   = '0;
                        state_d       = ACK;
                        d_rsp_valid_d = 1'b1;
                        d_rsp_data_d  = '0;
                    end
                end else if (reset_n && grant_if) begin
                    if_req_ready = 1'b1;
                    owner_d      = OWN_IF;
                    last_grant_d = OWN_IF;
                    addr_d       = if_addr;
                    mem_address  = if_addr;
                    mem_read_en  = 1'b1;
                    state_d      = RD_WAIT;
                end
            end
            RD_WAIT: begin
                state_d = IDLE;
                if (owner_q == OWN_IF) begin
                    if_rsp_valid_d = 1'b1;
                    if_rsp_data_d  = mem_data_o;
                end else begin
                    d_rsp_valid_d = 1'b1;
                    d_rsp_data_d  = mem_data_o;
                end
            end
            RMW: begin
                mem_write_en  = 1'b1;
                mem_address   = addr_q;
                mem_data_i    = merged;
                state_d       = ACK;
                d_rsp_valid_d = 1'b1;
                d_rsp_data_d  = '0;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered response outputs; reset drops any transaction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            owner_q        <= OWN_D;
            last_grant_q   <= OWN_D;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            d_rsp_valid_q  <= 1'b0;
            d_rsp_data_q   <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            d_rsp_valid_q  <= d_rsp_valid_d;
            d_rsp_data_q   <= d_rsp_data_d;
        end
    end

    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign d_rsp_valid  = d_rsp_valid_q;
    assign d_rsp_data   = d_rsp_data_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed transaction table, contention and
// reset sequences, then randomized traffic against a transaction-level model.
module tb_ram_arbiter;

    localparam int unsigned WS = 4;
    localparam int unsigned MS = 1024;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req_valid = 1'b0;
    logic          if_req_ready;
    logic [AW-1:0] if_addr = '0;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_data;
    logic          d_req_valid = 1'b0;
    logic          d_req_ready;
    logic          d_req_we = 1'b0;
    logic [WS-1:0] d_req_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_i;
    logic [DW-1:0] mem_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ram_arbiter #(.WORDSIZE(WS), .MEMSIZE(MS)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_we     (d_req_we),
        .d_req_be     (d_req_be),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_address  (mem_address),
        .mem_data_i   (mem_data_i),
        .mem_data_o   (mem_data_o)
    );

    // Single-port ram: read data appears the cycle after read_en.
    logic [DW-1:0] ram [MS];
    always @(posedge clock) begin
        if (mem_write_en) ram[mem_address] <= mem_data_i;
        if (mem_read_en)  mem_data_o <= ram[mem_address];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit            is_if;
        bit            we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int            lat;
        logic [31:0]   rdata;
        int            nrd;
        int            nwr;
        bit            chk_mem;
        logic [31:0]   mem;
    } vec_t;

    vec_t vecs[10];

    task automatic do_reset();
        @(negedge clock);
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        reset_n      = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Issue one request alone and follow it to its response.
    task automatic run_vec(input vec_t v, input string tag);
        logic        rdy;
        bit          got;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wseen;
        logic        rv;
        logic [31:0] rd;
        got = 0; lat = 0; nrd = 0; nwr = 0; wseen = '0;
        @(negedge clock);
        if (v.is_if) begin
            if_req_valid = 1'b1;
            if_addr      = v.addr;
        end else begin
            d_req_valid = 1'b1;
            d_req_we    = v.we;
            d_req_be    = v.be;
            d_addr      = v.addr;
            d_wdata     = v.wdata;
        end
        #1;
        rdy = v.is_if ? if_req_ready : d_req_ready;
        check({tag, " accept"}, rdy, 1'b1);
        nrd += int'(mem_read_en);
        nwr += int'(mem_write_en);
        if (mem_write_en) wseen = mem_data_i;
        if (mem_read_en || mem_write_en) check({tag, " addr"}, mem_address, v.addr);
        for (int l = 1; l <= 8 && !got; l++) begin
            @(negedge clock);
            if (l == 1) begin
                if_req_valid = 1'b0;
                d_req_valid  = 1'b0;
            end
            #1;
            nrd += int'(mem_read_en);
            nwr += int'(mem_write_en);
            if (mem_write_en) begin
                wseen = mem_data_i;
                check({tag, " rmw addr"}, mem_address, v.addr);
            end
            rv = v.is_if ? if_rsp_valid : d_rsp_valid;
            rd = v.is_if ? if_rsp_data : d_rsp_data;
            if (rv) begin
                got = 1;
                lat = l;
                check({tag, " rsp data"}, rd, v.rdata);
            end
        end
        check({tag, " rsp seen"}, got, 1'b1);
        check({tag, " latency"}, lat, v.lat);
        check({tag, " read enables"}, nrd, v.nrd);
        check({tag, " write enables"}, nwr, v.nwr);
        if (v.chk_mem && nwr > 0) check({tag, " write data"}, wseen, v.mem);
        if (v.chk_mem) check({tag, " ram word"}, ram[v.addr], v.mem);
    endtask

    // Transaction-level model state for randomized traffic.
    logic [31:0] shadow [16];
    bit          known  [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 4'hF, 10'h010, 32'hDEADBEEF, 1, 32'h0,        0, 1, 1'b1, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 4'h0, 10'h010, 32'h0,        2, 32'hDEADBEEF, 1, 0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 4'hF, 10'h020, 32'h12345678, 1, 32'h0,        0, 1, 1'b1, 32'h12345678};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 10'h020, 32'h0,        2, 32'h12345678, 1, 0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 4'hF, 10'h030, 32'hAABBCCDD, 1, 32'h0,        0, 1, 1'b1, 32'hAABBCCDD};
        vecs[5] = '{1'b0, 1'b1, 4'h2, 10'h030, 32'h0000EE00, 2, 32'h0,        1, 1, 1'b1, 32'hAABBEEDD};
        vecs[6] = '{1'b0, 1'b1, 4'h0, 10'h030, 32'hFFFFFFFF, 1, 32'h0,        0, 0, 1'b1, 32'hAABBEEDD};
        vecs[7] = '{1'b0, 1'b0, 4'h0, 10'h030, 32'h0,        2, 32'hAABBEEDD, 1, 0, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 1'b1, 4'h9, 10'h020, 32'h11FFFF22, 2, 32'h0,        1, 1, 1'b1, 32'h11345622};
        vecs[9] = '{1'b1, 1'b0, 4'h0, 10'h020, 32'h0,        2, 32'h11345622, 1, 0, 1'b0, 32'h0};

        // Reset state: all outputs low, requests ignored.
        d_req_valid = 1'b1;
        #1;
        check("reset outputs",
              {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_read_en,
               mem_write_en, mem_address, mem_data_i[19:0]}, '0);
        d_req_valid = 1'b0;
        do_reset();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Contention: both ports request continuously.
        begin
            owner_q_t: begin end
        end
        do_reset();
        begin
            bit exp_if [4];
            int ng;
            ng = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_if = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
            exp_if = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
            @(negedge clock);
            if_req_valid = 1'b1; if_addr = 10'h010;
            d_req_valid  = 1'b1; d_req_we = 1'b0; d_addr = 10'h020;
            for (int c = 0; c < 12 && ng < 4; c++) begin
                if (c > 0) @(negedge clock);
                #1;
                check("single ready", if_req_ready & d_req_ready, 1'b0);
                if (if_req_ready || d_req_ready) begin
                    check($sformatf("grant%0d", ng), if_req_ready, exp_if[ng]);
                    ng++;
                end
            end
            check("contention grants", ng, 4);
            @(negedge clock);
            if_req_valid = 1'b0;
            d_req_valid  = 1'b0;
            repeat (3) @(negedge clock);
        end

        // Reset during RD_WAIT drops the fetch.
        do_reset();
        @(negedge clock);
        if_req_valid = 1'b1; if_addr = 10'h010;
        #1;
        check("rst seq accept", if_req_ready, 1'b1);
        @(negedge clock);
        if_req_valid = 1'b0;
        reset_n      = 1'b0;
        d_req_valid  = 1'b1; d_req_we = 1'b0; d_addr = 10'h020;
        #1;
        check("mid-reset outputs",
              {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_read_en,
               mem_write_en, mem_address, mem_data_i[19:0]}, '0);
        @(negedge clock);
        #1;
        check("mid-reset no rsp", {if_rsp_valid, d_rsp_valid, d_req_ready, mem_read_en}, '0);
        d_req_valid = 1'b0;
        reset_n     = 1'b1;
        run_vec(vecs[1], "post-reset");

        // Randomized traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < 16; i++) known[i] = 1'b0;
        begin
            int          cyc;
            int          free_at;
            bit          pend;
            int          pend_cyc;
            bit          pend_if;
            logic [31:0] pend_data;
            bit          pend_known;
            bit          last_if;
            bit          avail;
            bit          gd;
            bit          gi;
            int          idx;
            cyc = 0; free_at = 0; pend = 0; pend_cyc = 0; pend_if = 0;
            pend_data = '0; pend_known = 0; last_if = 0;
            for (int n = 0; n < 600; n++) begin
                @(negedge clock);
                if_req_valid = 1'($urandom_range(0, 1));
                if_addr      = 10'h040 + 10'($urandom_range(0, 15));
                d_req_valid  = 1'($urandom_range(0, 1));
                d_req_we     = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       d_req_be = 4'hF;
                    1:       d_req_be = 4'h0;
                    default: d_req_be = 4'($urandom);
                endcase
                d_addr  = 10'h040 + 10'($urandom_range(0, 15));
                d_wdata = $urandom;
                #1;
                check("rnd if_rsp_valid", if_rsp_valid, pend && pend_cyc == cyc && pend_if);
                check("rnd d_rsp_valid", d_rsp_valid, pend && pend_cyc == cyc && !pend_if);
                if (pend && pend_cyc == cyc) begin
                    if (pend_known)
                        check("rnd rsp data", pend_if ? if_rsp_data : d_rsp_data, pend_data);
                    pend = 0;
                end
                check("rnd enable exclusion", mem_read_en & mem_write_en, 1'b0);
                avail = (cyc >= free_at);
`ifdef RAM_ARB_ROUND_ROBIN_EN
                gd = avail && d_req_valid && (!if_req_valid || last_if);
`else
                gd = avail && d_req_valid;
`endif
                gi = avail && if_req_valid && !gd;
                check("rnd d_req_ready", d_req_ready, gd);
                check("rnd if_req_ready", if_req_ready, gi);
                if (gi) begin
                    idx = int'(if_addr) - 'h40;
                    last_if = 1; pend = 1; pend_if = 1;
                    pend_cyc = cyc + 2; free_at = cyc + 2;
                    pend_data = shadow[idx]; pend_known = known[idx];
                end else if (gd) begin
                    idx = int'(d_addr) - 'h40;
                    last_if = 0; pend = 1; pend_if = 0;
                    if (!d_req_we) begin
                        pend_cyc = cyc + 2; free_at = cyc + 2;
                        pend_data = shadow[idx]; pend_known = known[idx];
                    end else begin
                        // A store acknowledges from its own ack cycle, so the next
                        // accept comes one cycle after the pulse.
                        pend_data = '0; pend_known = 1;
                        if (d_req_be == 4'hF || d_req_be == 4'h0) begin
                            pend_cyc = cyc + 1; free_at = cyc + 2;
                        end else begin
                            pend_cyc = cyc + 2; free_at = cyc + 3;
                        end
                        if (d_req_be == 4'hF) begin
                            shadow[idx] = d_wdata;
                            known[idx]  = 1'b1;
                        end else begin
                            for (int b = 0; b < 4; b++)
                                if (d_req_be[b]) shadow[idx][b*8 +: 8] = d_wdata[b*8 +: 8];
                        end
                    end
                end
                cyc++;
            end
            @(negedge clock);
            if_req_valid = 1'b0;
            d_req_valid  = 1'b0;
            repeat (4) @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
